irq_sequencer: RTL and testbench
================================

# irq_sequencer

Sequences external interrupt requests into the CP0 `interruptSignal` input of the ID stage. It latches rising edges on the interrupt lines, applies the status mask and fixed priority, and waits for a safe ID-stage slot: not stalled, not a branch/jump, and no synchronous exception in flight. It then issues one one-hot request per handler entry and holds off further requests until CP0 reports `exceptClear` (eret). It sits between the SoC interrupt sources and the ID stage.

## Interface
Parameters:
- NUM_IRQ, 3, number of interrupt lines; fixed at 3 to match CP0 `interruptSignal` width.

Ports:
- clk  input  1  pipeline clock; everything on rising edge.
- rst  input  1  synchronous, active-high reset.
- irq_in  input  NUM_IRQ  level interrupt lines, already synchronous to clk.
- irq_mask  input  NUM_IRQ  per-line enable from CP0 status; 1 = enabled.
- global_ie  input  1  global interrupt enable from CP0 status.
- id_stall  input  1  ID stage `shouldStall`.
- id_branch  input  1  ID stage `shouldJumpOrBranch`.
- sync_exc  input  1  synchronous exception being taken (`epc_ctrl` or undefined/overflow).
- exceptClear  input  1  one-cycle pulse from CP0 on eret.
- interruptSignal  output  NUM_IRQ  one-hot request to CP0, asserted for exactly one cycle per issue.
- irq_pending  output  NUM_IRQ  latched pending edges (debug and status).
- irq_busy  output  1  high in ARM, ISSUE and SERVICE.

## Operation
- Edge capture: register `irq_q`; `rise = irq_in & ~irq_q`. Each `rise` bit sets `irq_pending`. A pending bit clears only in the ISSUE cycle for the issued line.
- Same-cycle set and clear on one line: set wins, so the new edge stays pending.
- Eligible lines: `elig = irq_pending & irq_mask`, gated by `global_ie`. Priority is fixed, with bit 0 highest. `sel` is the one-hot lowest set bit of `elig`.
- Safe slot: `~id_stall & ~id_branch & ~sync_exc`.
- States:
  - IDLE → ARM when `elig != 0`.
  - ARM → ISSUE when the safe slot holds and `elig != 0`. The grant register `gnt <= sel` is captured on this transition.
  - ARM → IDLE when `elig` becomes 0 (mask or global_ie dropped); nothing is issued.
  - ARM stays in ARM while the slot is unsafe. No timeout.
  - ISSUE: `interruptSignal = gnt` for one cycle, clear `irq_pending & gnt`, then go to SERVICE unconditionally.
  - SERVICE: `interruptSignal = 0`. New edges keep accumulating in `irq_pending`. Go to IDLE on `exceptClear`. No nesting.
- `exceptClear` seen in IDLE, ARM or ISSUE is ignored.
- `sync_exc` during ISSUE does not cancel the issue; CP0 arbitrates between the two.
- Reset: state IDLE, `irq_q = irq_in` sampled as 0, so a line held high at reset release produces an edge. `irq_pending = 0`, `gnt = 0`, `interruptSignal = 0`, `irq_busy = 0`. Reset mid-SERVICE abandons the handler; pending edges are lost.

## Timing
- `interruptSignal` is a registered output: it is driven from `gnt` and the ISSUE state, with no combinational path from any input.
- Minimum latency, with a safe slot throughout:
  - cycle 0: `irq_in` rises.
  - cycle 1: `irq_pending` set, state ARM.
  - cycle 2: state ISSUE, `interruptSignal` high.
- `irq_busy` rises the cycle after IDLE→ARM. It falls the cycle after `exceptClear` in SERVICE.
- After `exceptClear`, one IDLE cycle precedes the next ARM. Back-to-back interrupts therefore issue no sooner than 3 cycles after eret.

## Structure
- Shared package `irq_pkg`:
  - state encoding `IRQ_IDLE=2'd0`, `IRQ_ARM=2'd1`, `IRQ_ISSUE=2'd2`, `IRQ_SERVICE=2'd3`;
  - `NUM_IRQ = 3`.
- One natural sub-module: `irq_prio_enc`, a combinational lowest-bit-first one-hot selector over NUM_IRQ bits.
- Edge detection, pending register and FSM live in the top.

## Test plan
- Single edge, safe slot: `irq_in=3'b010` at cycle 0, mask 3'b111, ie=1, no stall → `interruptSignal=3'b010` at cycle 2 only, `irq_pending=0` at cycle 3, `irq_busy` stays high until `exceptClear`, then low the next cycle.
- Priority: `irq_in` rises 3'b110 in one cycle → first issue 3'b010. After `exceptClear`, second issue 3'b100 with 3 cycles between the eret and the issue.
- Unsafe slot: with pending 3'b001, hold `id_stall=1` for 5 cycles, then `id_branch=1` for 1 cycle → no issue while either is high; issue 3'b001 in the first cycle both are low.
- Mask withdrawal: pending 3'b100 in ARM, drop `irq_mask[2]` → return to IDLE, `interruptSignal` never asserts, `irq_pending` stays 3'b100. Re-enable the mask → issue 3'b100 two cycles later.
- Accumulate during SERVICE: in SERVICE, a rise on line 0 → `irq_pending=3'b001`, no issue until `exceptClear`, then ARM and issue 3'b001.
- Reset mid-SERVICE, plus set/clear collision: assert `rst` in SERVICE → all outputs 0 next cycle. Separately, re-pulse the issued line in its ISSUE cycle → its pending bit remains 1.

Source files
------------

// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared constants and state encoding for the interrupt sequencer
package irq_pkg;

  localparam int NUM_IRQ = 3;

  typedef enum logic [1:0] {
    IRQ_IDLE    = 2'd0,
    IRQ_ARM     = 2'd1,
    IRQ_ISSUE   = 2'd2,
    IRQ_SERVICE = 2'd3
  } irqState_t;

endpackage

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - lowest-bit-first one-hot priority selector
module irq_prio_enc #(
  parameter int WIDTH = irq_pkg::NUM_IRQ
) (
  input  logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] sel
);

  logic found;

  // Walk from bit 0 upward and keep only the first request seen.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (req[i] && !found) begin
        sel[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_sequencer.sv
// rtl/irq_sequencer.sv - edge-latching interrupt sequencer feeding CP0 interruptSignal
module irq_sequencer #(
  parameter int NUM_IRQ = irq_pkg::NUM_IRQ
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [NUM_IRQ-1:0] irq_mask,
  input  logic               global_ie,
  input  logic               id_stall,
  input  logic               id_branch,
  input  logic               sync_exc,
  input  logic               exceptClear,
  output logic [NUM_IRQ-1:0] interruptSignal,
  output logic [NUM_IRQ-1:0] irq_pending,
  output logic               irq_busy
);

  import irq_pkg::*;

  irqState_t          state;
  logic [NUM_IRQ-1:0] irqQ;
  logic [NUM_IRQ-1:0] pend;
  logic [NUM_IRQ-1:0] gnt;
  logic [NUM_IRQ-1:0] intSig;
  logic               busy;

  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] enableMask;
  logic [NUM_IRQ-1:0] elig;
  logic [NUM_IRQ-1:0] eligNow;
  logic [NUM_IRQ-1:0] sel;
  logic [NUM_IRQ-1:0] clr;
  logic               safeSlot;

  assign rise       = irq_in & ~irqQ;
  assign enableMask = irq_mask & {NUM_IRQ{global_ie}};
  assign elig       = pend & enableMask;
  // IDLE also looks at this cycle's edges so an edge can arm on the very next cycle.
  assign eligNow    = (pend | rise) & enableMask;
  assign safeSlot   = ~id_stall & ~id_branch & ~sync_exc;
  assign clr        = (state == IRQ_ISSUE) ? gnt : '0;

  irq_prio_enc #(.WIDTH(NUM_IRQ)) uPrioEnc (
    .req (elig),
    .sel (sel)
  );

  // Edge capture and pending latch; a new edge wins over the issue-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      irqQ <= '0;
      pend <= '0;
    end else begin
      irqQ <= irq_in;
      pend <= (pend & ~clr) | rise;
    end
  end

  // Sequencing FSM with registered request, grant and busy outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IRQ_IDLE;
      gnt    <= '0;
      intSig <= '0;
      busy   <= 1'b0;
    end else begin
      intSig <= '0;
      case (state)
        IRQ_IDLE: begin
          if (eligNow != '0) begin
            state <= IRQ_ARM;
            busy  <= 1'b1;
          end
        end
        IRQ_ARM: begin
          if (elig == '0) begin
            state <= IRQ_IDLE;
            busy  <= 1'b0;
          end else if (safeSlot) begin
            state  <= IRQ_ISSUE;
            gnt    <= sel;
            intSig <= sel;
          end
        end
        IRQ_ISSUE: begin
          state <= IRQ_SERVICE;
        end
        IRQ_SERVICE: begin
          if (exceptClear) begin
            state <= IRQ_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IRQ_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign interruptSignal = intSig;
  assign irq_pending     = pend;
  assign irq_busy        = busy;

endmodule

// File: tb/tb_irq_sequencer.sv
// tb/tb_irq_sequencer.sv - directed and randomized self-checking bench for irq_sequencer
module tb_irq_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] irq_in;
  logic [2:0] irq_mask;
  logic       global_ie;
  logic       id_stall;
  logic       id_branch;
  logic       sync_exc;
  logic       exceptClear;
  logic [2:0] interruptSignal;
  logic [2:0] irq_pending;
  logic       irq_busy;

  int checks   = 0;
  int failures = 0;

  irq_sequencer #(.NUM_IRQ(3)) dut (
    .clk             (clk),
    .rst             (rst),
    .irq_in          (irq_in),
    .irq_mask        (irq_mask),
    .global_ie       (global_ie),
    .id_stall        (id_stall),
    .id_branch       (id_branch),
    .sync_exc        (sync_exc),
    .exceptClear     (exceptClear),
    .interruptSignal (interruptSignal),
    .irq_pending     (irq_pending),
    .irq_busy        (irq_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks what the sequencer is doing in terms of
  // "waiting for a slot", "request going out now" and "inside a handler".
  bit   modelValid = 0;
  bit   mPend [3];
  bit   mPrev [3];
  bit   mWaiting;
  int   mIssuing;
  bit   mInHandler;
  logic [2:0] expInt;
  logic [2:0] expPend;
  logic       expBusy;

  always @(posedge clk) begin
    bit rz [3];
    bit anyElig;
    bit anyEligNow;
    int first;
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        mPend[i] = 0;
        mPrev[i] = 0;
      end
      mWaiting   = 0;
      mIssuing   = -1;
      mInHandler = 0;
      modelValid = 1;
    end else begin
      anyElig    = 0;
      anyEligNow = 0;
      first      = -1;
      for (int i = 0; i < 3; i++) begin
        rz[i] = irq_in[i] && !mPrev[i];
        if (mPend[i] && irq_mask[i] && global_ie) begin
          anyElig = 1;
          if (first < 0) first = i;
        end
        if ((mPend[i] || rz[i]) && irq_mask[i] && global_ie) anyEligNow = 1;
      end
      if (mInHandler) begin
        if (exceptClear) mInHandler = 0;
      end else if (mIssuing >= 0) begin
        mPend[mIssuing] = 0;
        mIssuing   = -1;
        mInHandler = 1;
      end else if (mWaiting) begin
        if (!anyElig) mWaiting = 0;
        else if (!id_stall && !id_branch && !sync_exc) begin
          mIssuing = first;
          mWaiting = 0;
        end
      end else if (anyEligNow) begin
        mWaiting = 1;
      end
      for (int i = 0; i < 3; i++) begin
        if (rz[i]) mPend[i] = 1;
        mPrev[i] = irq_in[i];
      end
    end
    expInt  = (mIssuing >= 0) ? 3'(1 << mIssuing) : 3'b000;
    expBusy = mWaiting || (mIssuing >= 0) || mInHandler;
    for (int i = 0; i < 3; i++) expPend[i] = mPend[i];
  end

  // Compare every cycle once the model has seen a reset.
  always @(negedge clk) begin
    if (modelValid) begin
      check("model_interruptSignal", int'(interruptSignal), int'(expInt));
      check("model_irq_pending", int'(irq_pending), int'(expPend));
      check("model_irq_busy", int'(irq_busy), int'(expBusy));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic eret();
    exceptClear = 1'b1;
    step();
    exceptClear = 1'b0;
  endtask

  initial begin
    rst = 1'b1; irq_in = 3'b000; irq_mask = 3'b111; global_ie = 1'b1;
    id_stall = 1'b0; id_branch = 1'b0; sync_exc = 1'b0; exceptClear = 1'b0;
    step(); step();
    check("reset_int", int'(interruptSignal), 0);
    check("reset_pend", int'(irq_pending), 0);
    check("reset_busy", int'(irq_busy), 0);
    rst = 1'b0;
    step();

    // Single edge with a safe slot.
    irq_in = 3'b010;
    step();
    check("single_pend_c1", int'(irq_pending), 2);
    check("single_int_c1", int'(interruptSignal), 0);
    check("single_busy_c1", int'(irq_busy), 1);
    irq_in = 3'b000;
    step();
    check("single_int_c2", int'(interruptSignal), 2);
    step();
    check("single_int_c3", int'(interruptSignal), 0);
    check("single_pend_c3", int'(irq_pending), 0);
    step(); step(); step();
    check("single_busy_hold", int'(irq_busy), 1);
    eret();
    check("single_busy_after_eret", int'(irq_busy), 0);

    // Priority and back-to-back spacing after eret.
    irq_in = 3'b110;
    step();
    check("prio_pend", int'(irq_pending), 6);
    step();
    check("prio_first", int'(interruptSignal), 2);
    irq_in = 3'b000;
    step();
    check("prio_pend_left", int'(irq_pending), 4);
    step();
    eret();
    check("prio_e1_int", int'(interruptSignal), 0);
    check("prio_e1_busy", int'(irq_busy), 0);
    step();
    check("prio_e2_int", int'(interruptSignal), 0);
    step();
    check("prio_second", int'(interruptSignal), 4);
    step();
    eret();

    // Unsafe slot: stall then branch hold the request off.
    id_stall = 1'b1;
    irq_in = 3'b001;
    step();
    check("unsafe_pend", int'(irq_pending), 1);
    irq_in = 3'b000;
    for (int i = 0; i < 4; i++) begin
      step();
      check("unsafe_stall_int", int'(interruptSignal), 0);
    end
    id_stall = 1'b0; id_branch = 1'b1;
    step();
    check("unsafe_branch_int", int'(interruptSignal), 0);
    id_branch = 1'b0;
    step();
    check("unsafe_issue", int'(interruptSignal), 1);
    step();
    eret();

    // Mask withdrawal while armed.
    id_stall = 1'b1;
    irq_in = 3'b100;
    step();
    check("mask_armed_busy", int'(irq_busy), 1);
    irq_in = 3'b000; irq_mask = 3'b011;
    step();
    check("mask_drop_busy", int'(irq_busy), 0);
    check("mask_drop_pend", int'(irq_pending), 4);
    id_stall = 1'b0;
    step();
    check("mask_idle_int", int'(interruptSignal), 0);
    step();
    irq_mask = 3'b111;
    step();
    check("mask_rearm_int", int'(interruptSignal), 0);
    step();
    check("mask_issue", int'(interruptSignal), 4);
    step();
    eret();

    // Accumulate a new edge during SERVICE.
    irq_in = 3'b010;
    step();
    irq_in = 3'b000;
    step();
    step();
    irq_in = 3'b001;
    step();
    check("acc_pend", int'(irq_pending), 1);
    irq_in = 3'b000;
    step(); step();
    check("acc_no_issue", int'(interruptSignal), 0);
    check("acc_busy", int'(irq_busy), 1);
    eret();
    check("acc_idle_busy", int'(irq_busy), 0);
    step();
    step();
    check("acc_issue", int'(interruptSignal), 1);
    step();
    eret();

    // Set/clear collision on the issued line, then reset mid-SERVICE.
    irq_in = 3'b010;
    step();
    irq_in = 3'b000;
    step();
    irq_in = 3'b010;
    step();
    check("collide_pend", int'(irq_pending), 2);
    rst = 1'b1;
    step();
    check("rst_mid_int", int'(interruptSignal), 0);
    check("rst_mid_pend", int'(irq_pending), 0);
    check("rst_mid_busy", int'(irq_busy), 0);
    rst = 1'b0; irq_in = 3'b000;
    step();

    // Randomized traffic checked by the model.
    for (int n = 0; n < 4000; n++) begin
      irq_in      = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) irq_mask = 3'($urandom_range(0, 7));
      global_ie   = ($urandom_range(0, 15) != 0);
      id_stall    = ($urandom_range(0, 9) < 3);
      id_branch   = ($urandom_range(0, 9) < 2);
      sync_exc    = ($urandom_range(0, 9) < 1);
      exceptClear = ($urandom_range(0, 6) == 0);
      rst         = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0; exceptClear = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
